// File: rtl/util_gmii_crossover_pkg.sv
// Shared definitions for the GMII crossover: data width, per-direction FSM
// encoding, pipeline beat layout and legal parameter ranges.
package util_gmii_crossover_pkg;

    localparam int GMII_W      = 8;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 8;
    localparam int CNT_W_MIN   = 8;
    localparam int CNT_W_MAX   = 32;

    typedef enum logic [1:0] {
        XFER_IDLE = 2'd0,
        XFER_PASS = 2'd1,
        XFER_DROP = 2'd2
    } xfer_state_e;

    typedef struct packed {
        logic              dv;
        logic              er;
        logic [GMII_W-1:0] d;
    } gmii_beat_t;

endpackage

// File: rtl/util_gmii_xfer.sv
// One crossover direction: frame-aware forward/drop FSM, fixed-depth output
// pipeline and saturating frame/drop/error counters.
module util_gmii_xfer
    import util_gmii_crossover_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [GMII_W-1:0] txd,
    input  logic              tx_en,
    input  logic              tx_er,
    input  logic              en,
    input  logic              clear_counters,
    output logic [GMII_W-1:0] rxd,
    output logic              rx_dv,
    output logic              rx_er,
    output logic [CNT_W-1:0]  frames,
    output logic [CNT_W-1:0]  drops,
    output logic [CNT_W-1:0]  errors
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    xfer_state_e      state_q, state_d;
    logic             tx_en_prev_q, tx_en_prev_d;
    logic             armed_q, armed_d;
    logic             err_seen_q, err_seen_d;
    gmii_beat_t       pipe_q [LATENCY];
    gmii_beat_t       pipe_d [LATENCY];
    logic [CNT_W-1:0] frames_q, frames_d;
    logic [CNT_W-1:0] drops_q, drops_d;
    logic [CNT_W-1:0] errors_q, errors_d;

    logic frame_start;
    logic fwd;
    logic frame_done;
    logic drop_start;

    // armed_q stays low after reset until tx_en is seen low, so a frame
    // already in flight across reset is never taken as a new frame start.
    assign frame_start = tx_en && !tx_en_prev_q && armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= XFER_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            XFER_IDLE: begin
                if (frame_start) begin
                    state_d = en ? XFER_PASS : XFER_DROP;
                end
            end
            XFER_PASS, XFER_DROP: begin
                if (!tx_en) begin
                    state_d = XFER_IDLE;
                end
            end
            default: state_d = XFER_IDLE;
        endcase
    end

    always_comb begin
        fwd        = 1'b0;
        frame_done = 1'b0;
        drop_start = 1'b0;
        case (state_q)
            XFER_IDLE: begin
                fwd        = frame_start && en;
                drop_start = frame_start && !en;
            end
            XFER_PASS: begin
                fwd        = tx_en;
                frame_done = !tx_en;
            end
            default: ;
        endcase
    end

    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             clr
    );
        if (clr) begin
            return '0;
        end
        if (inc && (cur != CNT_MAX)) begin
            return cur + CNT_ONE;
        end
        return cur;
    endfunction

    always_comb begin
        tx_en_prev_d = tx_en;
        armed_d      = armed_q | !tx_en;

        err_seen_d = err_seen_q;
        if (state_q == XFER_IDLE) begin
            err_seen_d = fwd & tx_er;
        end else if (fwd) begin
            err_seen_d = err_seen_q | tx_er;
        end

        pipe_d[0] = '0;
        if (fwd) begin
            pipe_d[0].dv = 1'b1;
            pipe_d[0].er = tx_er;
            pipe_d[0].d  = txd;
        end
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        frames_d = cnt_next(frames_q, frame_done, clear_counters);
        errors_d = cnt_next(errors_q, frame_done && err_seen_q, clear_counters);
        drops_d  = cnt_next(drops_q, drop_start, clear_counters);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_en_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            err_seen_q   <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            frames_q <= '0;
            drops_q  <= '0;
            errors_q <= '0;
        end else begin
            tx_en_prev_q <= tx_en_prev_d;
            armed_q      <= armed_d;
            err_seen_q   <= err_seen_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            frames_q <= frames_d;
            drops_q  <= drops_d;
            errors_q <= errors_d;
        end
    end

    assign rxd    = pipe_q[LATENCY-1].d;
    assign rx_dv  = pipe_q[LATENCY-1].dv;
    assign rx_er  = pipe_q[LATENCY-1].er;
    assign frames = frames_q;
    assign drops  = drops_q;
    assign errors = errors_q;

endmodule

// File: rtl/util_gmii_crossover.sv
// GMII MAC-to-MAC crossover: A transmit feeds B receive and vice versa, each
// through an independent util_gmii_xfer, behind a shared reset synchroniser.
module util_gmii_crossover
    import util_gmii_crossover_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [GMII_W-1:0] s_gmii_a_txd,
    input  logic              s_gmii_a_tx_en,
    input  logic              s_gmii_a_tx_er,
    output logic [GMII_W-1:0] s_gmii_a_rxd,
    output logic              s_gmii_a_rx_dv,
    output logic              s_gmii_a_rx_er,
    input  logic [GMII_W-1:0] s_gmii_b_txd,
    input  logic              s_gmii_b_tx_en,
    input  logic              s_gmii_b_tx_er,
    output logic [GMII_W-1:0] s_gmii_b_rxd,
    output logic              s_gmii_b_rx_dv,
    output logic              s_gmii_b_rx_er,
    input  logic              ab_en,
    input  logic              ba_en,
    input  logic              clear_counters,
    output logic [CNT_W-1:0]  ab_frames,
    output logic [CNT_W-1:0]  ab_drops,
    output logic [CNT_W-1:0]  ab_errors,
    output logic [CNT_W-1:0]  ba_frames,
    output logic [CNT_W-1:0]  ba_drops,
    output logic [CNT_W-1:0]  ba_errors
);

    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_sync;

    // Assertion propagates asynchronously; release takes two clock edges.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_sync = rst_sync_q[1];

    util_gmii_xfer #(
        .LATENCY (LATENCY),
        .CNT_W   (CNT_W)
    ) u_xfer_ab (
        .clk            (clk),
        .rst_n          (rst_n_sync),
        .txd            (s_gmii_a_txd),
        .tx_en          (s_gmii_a_tx_en),
        .tx_er          (s_gmii_a_tx_er),
        .en             (ab_en),
        .clear_counters (clear_counters),
        .rxd            (s_gmii_b_rxd),
        .rx_dv          (s_gmii_b_rx_dv),
        .rx_er          (s_gmii_b_rx_er),
        .frames         (ab_frames),
        .drops          (ab_drops),
        .errors         (ab_errors)
    );

    util_gmii_xfer #(
        .LATENCY (LATENCY),
        .CNT_W   (CNT_W)
    ) u_xfer_ba (
        .clk            (clk),
        .rst_n          (rst_n_sync),
        .txd            (s_gmii_b_txd),
        .tx_en          (s_gmii_b_tx_en),
        .tx_er          (s_gmii_b_tx_er),
        .en             (ba_en),
        .clear_counters (clear_counters),
        .rxd            (s_gmii_a_rxd),
        .rx_dv          (s_gmii_a_rx_dv),
        .rx_er          (s_gmii_a_rx_er),
        .frames         (ba_frames),
        .drops          (ba_drops),
        .errors         (ba_errors)
    );

endmodule

// File: doc/util_gmii_crossover.md
# util_gmii_crossover

Bidirectional GMII crossover for two MACs sharing one 125 MHz clock: frames a MAC transmits on port A are presented as receive data to the MAC on port B, and B is presented to A. Each direction has a frame-boundary-aware enable, used to emulate link up/down without truncating frames. Each direction also has a fixed pipeline latency and saturating per-direction statistics counters. The block sits at the GMII level, upstream of the SGMII PCS/PMA, for MAC-to-MAC loopback tests without transceivers.

## Interface
- LATENCY, 2, input-to-output pipeline depth in cycles, legal 1..8
- CNT_W, 32, statistics counter width, legal 8..32
- clk  in  1  125 MHz GMII clock, common to both ports
- rst_n  in  1  asynchronous active-low reset
- s_gmii_a_txd / s_gmii_a_tx_en / s_gmii_a_tx_er  in  8/1/1  MAC A transmit
- s_gmii_a_rxd / s_gmii_a_rx_dv / s_gmii_a_rx_er  out  8/1/1  MAC A receive (sourced from B)
- s_gmii_b_txd / s_gmii_b_tx_en / s_gmii_b_tx_er  in  8/1/1  MAC B transmit
- s_gmii_b_rxd / s_gmii_b_rx_dv / s_gmii_b_rx_er  out  8/1/1  MAC B receive (sourced from A)
- ab_en, ba_en  in  1 each  direction enable (A→B, B→A), level, may change any cycle
- clear_counters  in  1  synchronous clear of all counters
- ab_frames, ab_drops, ab_errors  out  CNT_W each  A→B statistics
- ba_frames, ba_drops, ba_errors  out  CNT_W each  B→A statistics

## Operation
- Each direction runs an independent FSM, sampled on input side:
  - IDLE: on tx_en rising edge (tx_en=1, previous tx_en=0), go to PASS if en=1, else go to DROP.
  - PASS: forward every byte; when tx_en=0, return to IDLE.
  - DROP: forward nothing; when tx_en=0, return to IDLE.
- The enable is sampled only on the frame's first byte. Changes mid-frame take effect at the next frame start; no frame is ever truncated or partially emitted.
- Forwarded byte: rx_dv=1, rxd=txd, rx_er=tx_er.
- Non-forwarded cycles (IDLE, DROP, tx_en=0): rx_dv=0, rxd=0x00, rx_er=0. Carrier extension and false-carrier tx_er are not propagated.
- frames: +1 per frame fully forwarded, counted on the cycle after its last byte.
- errors: +1 per forwarded frame with tx_er=1 on at least one byte, counted with frames.
- drops: +1 per frame entering DROP, counted on its first byte.
- Counters saturate at 2^CNT_W−1. clear_counters coinciding with an increment yields 0 (clear wins).
- A frame of one byte (tx_en high one cycle) is a valid frame.
- Back-to-back frames (zero gap) are impossible in GMII. If tx_en stays high, it is one frame.

## Timing
- Reset (async assert): all rx outputs 0, all counters 0, FSMs IDLE, pipeline contents 0, previous-tx_en registers 0.
  - Deassertion is synchronised internally; the first active edge is the one after synchronised release.
  - Reset mid-frame discards the frame. A still-high tx_en after reset is not a rising edge, so it is not forwarded and not counted.
- Latency: input byte at edge N appears on rx outputs after edge N+LATENCY. The FSM adds no cycles; total latency is exactly LATENCY.
- Counter updates are visible one cycle after the qualifying event. They are not delayed by LATENCY.
- The two directions are fully independent, including same-cycle frame starts and clears.

## Structure
- Shared package: GMII data width (8), FSM state encoding (IDLE/PASS/DROP), LATENCY legal range.
- Sub-module util_gmii_xfer: one direction, containing the FSM, delay pipeline and three counters. The top level instantiates it twice with crossed wiring plus the reset synchroniser.

## Test plan
- ab_en=1, 64-byte frame 0x00..0x3F on A → identical bytes on B rx, rx_dv high exactly 64 cycles, starting LATENCY cycles later; ab_frames=1; B→A idle.
- ab_en=0 at frame start, raised on byte 10 → B rx_dv never asserts, ab_drops=1. Next frame forwarded in full, ab_frames=1.
- ab_en dropped on byte 20 of a 100-byte forwarded frame → all 100 bytes emitted, ab_frames=1; next frame dropped, ab_drops=1.
- tx_er on byte 5 of a frame, plus tx_er=1 with tx_en=0 between frames → rx_er high on byte 5 only, ab_errors=1, no rx_er outside rx_dv.
- Preload ab_frames to all ones at CNT_W=8, send a frame → stays 0xFF. Assert clear_counters on the increment cycle → 0.
- Assert rst_n low mid-frame on both directions, simultaneous frames, LATENCY=1 and 8 → outputs 0 immediately, counters 0, remainder of frames not forwarded.
